// File: rtl/vga_pkg.sv
// Shared VGA test-pattern definitions: timing defaults, 12-bit colour type,
// colour-bar palette and the scroller state enum.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT  = 640;
  localparam int BAR_WIDTH_DEFAULT = 80;
  localparam int BAR_COUNT         = 8;

  typedef logic [11:0] rgb_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    RUN        = 2'd1,
    HOLD       = 2'd2
  } scroll_state_t;

  // Bar 0 (white) occupies the least-significant 12-bit slot.
  localparam logic [BAR_COUNT*12-1:0] PALETTE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic rgb_t palette_rgb(input logic [2:0] idx);
    rgb_t colour;
    colour = '0;
    for (int i = 0; i < BAR_COUNT; i++) begin
      if (idx == 3'(i)) colour = PALETTE[i*12 +: 12];
    end
    return colour;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for sync/video flags; every stage resets to all-ones
// so active-low syncs read inactive while the pipeline is being refilled.
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] tap1,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '1;
    end else begin
      stage_reg[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign tap1    = stage_reg[0];
  assign delayed = stage_reg[DEPTH-1];

endmodule

// File: rtl/scroll_bars.sv
// Eight vertical colour bars with a 2-cycle pixel pipeline. With SCROLL_BARS_SCROLL_EN
// defined the bars scroll by speed+1 pixels per frame (pausable); otherwise they are static.
module scroll_bars
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEFAULT,
  parameter int BAR_WIDTH = BAR_WIDTH_DEFAULT
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on,
  input  logic [9:0] horizontal_num,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam logic [10:0] H_LIMIT = 11'(H_ACTIVE);
  localparam logic [9:0]  BAR_W   = 10'(BAR_WIDTH);

  scroll_state_t state_reg, state_next;
  logic [9:0]    offset_reg, offset_next;
  logic          vsync_prev_reg;
  logic          frame_tick;
  logic [9:0]    column;
  logic [10:0]   pos_sum;
  logic [9:0]    pos_reg, pos_next;
  logic [2:0]    bar_idx;
  rgb_t          rgb_reg, rgb_next;
  logic [2:0]    sync_tap1, sync_tap2;
  logic          unused_taps;

  assign frame_tick = vsync_prev_reg & ~vsync_in;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      vsync_prev_reg <= 1'b1;
      state_reg      <= WAIT_FRAME;
      offset_reg     <= '0;
    end else begin
      vsync_prev_reg <= vsync_in;
      state_reg      <= state_next;
      offset_reg     <= offset_next;
    end
  end

`ifdef SCROLL_BARS_SCROLL_EN
  logic [10:0] offset_sum;
  assign offset_sum = {1'b0, offset_reg} + {9'd0, speed} + 11'd1;

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    if (frame_tick) begin
      case (state_reg)
        WAIT_FRAME: state_next = pause ? HOLD : RUN;
        RUN: begin
          if (pause) state_next = HOLD;
          else offset_next = (offset_sum >= H_LIMIT) ? 10'(offset_sum - H_LIMIT)
                                                     : offset_sum[9:0];
        end
        HOLD:    if (!pause) state_next = RUN;
        default: state_next = WAIT_FRAME;
      endcase
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{pause, speed};

  always_comb begin
    state_next  = state_reg;
    offset_next = '0;
    if (frame_tick && state_reg == WAIT_FRAME) state_next = RUN;
  end
`endif

  // Stage 1: scrolled column, folded back into the visible line by one subtract.
  assign column   = ({1'b0, horizontal_num} >= H_LIMIT) ? 10'd0 : horizontal_num;
  assign pos_sum  = {1'b0, column} + {1'b0, offset_reg};
  assign pos_next = (pos_sum >= H_LIMIT) ? 10'(pos_sum - H_LIMIT) : pos_sum[9:0];

  // Stage 2: bar lookup; video_on travels inverted so the all-ones reset means blanked.
  assign bar_idx  = 3'(pos_reg / BAR_W);
  assign rgb_next = (state_reg != WAIT_FRAME && !sync_tap1[0]) ? palette_rgb(bar_idx) : '0;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      pos_reg <= '0;
      rgb_reg <= '0;
    end else begin
      pos_reg <= pos_next;
      rgb_reg <= rgb_next;
    end
  end

  sync_delay #(
    .WIDTH(3),
    .DEPTH(2)
  ) u_sync_delay (
    .clk    (clk_25),
    .rst    (rst),
    .data   ({hsync_in, vsync_in, ~video_on}),
    .tap1   (sync_tap1),
    .delayed(sync_tap2)
  );

  assign unused_taps = ^{sync_tap1[2:1], sync_tap2[0]};

  assign red       = rgb_reg[11:8];
  assign green     = rgb_reg[7:4];
  assign blue      = rgb_reg[3:0];
  assign hsync_out = sync_tap2[2];
  assign vsync_out = sync_tap2[1];

endmodule

// File: tb/tb_scroll_bars.sv
// Randomized scoreboard bench for scroll_bars; follows SCROLL_BARS_SCROLL_EN if defined.
module tb_scroll_bars;

  localparam int H  = 640;
  localparam int BW = 80;
`ifdef SCROLL_BARS_SCROLL_EN
  localparam bit SCROLL_EN = 1'b1;
`else
  localparam bit SCROLL_EN = 1'b0;
`endif

  logic       clk_25 = 1'b0;
  logic       rst;
  logic       hsync_in, vsync_in, video_on, pause;
  logic [9:0] horizontal_num;
  logic [1:0] speed;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out;

  scroll_bars dut (
    .clk_25        (clk_25),
    .rst           (rst),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .video_on      (video_on),
    .horizontal_num(horizontal_num),
    .pause         (pause),
    .speed         (speed),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    int          due;
    int          id;
    logic [13:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   txn = 0;

  // Reference model: bars in left-to-right order, scroll offset, frame bookkeeping.
  logic [11:0] pal [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                           12'hF0F, 12'hF00, 12'h00F, 12'h000};
  int m_offset  = 0;
  bit m_started = 0;
  bit m_frozen  = 0;
  bit m_vs_prev = 1;

  task automatic check(string name, logic [13:0] got, logic [13:0] want);
    checks++;
    if (got === want) begin
      passed++;
      $display("ok   %s rgb/hs/vs=%h", name, got);
    end else begin
      $display("FAIL %s: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
               name, got[13:2], got[1], got[0], want[13:2], want[1], want[0]);
    end
  endtask

  function automatic logic [11:0] exp_rgb(int hn, bit von);
    int p;
    if (!m_started || !von) return 12'h000;
    if (hn > H - 1) hn = 0;
    p = (hn + m_offset) % H;
    return pal[p / BW];
  endfunction

  task automatic model_boundary(bit p, int spd);
    if (SCROLL_EN && m_started && !m_frozen && !p) m_offset = (m_offset + spd + 1) % H;
    m_frozen  = SCROLL_EN && p;
    m_started = 1'b1;
  endtask

  task automatic drive(bit hs, bit vs, bit von, int hn);
    exp_t e;
    @(posedge clk_25);
    #2;
    hsync_in       = hs;
    vsync_in       = vs;
    video_on       = von;
    horizontal_num = 10'(hn);
    if (m_vs_prev && !vs) model_boundary(pause, int'(speed));
    m_vs_prev = vs;
    e.due = cyc + 2;
    e.id  = txn++;
    e.val = {exp_rgb(hn, von), hs, vs};
    q.push_back(e);
  endtask

  task automatic frame(int n_pix);
    int hn;
    pause = ($urandom_range(0, 3) == 0);
    speed = 2'($urandom_range(0, 3));
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    // Changes after the boundary must not affect this frame's step.
    speed = 2'($urandom_range(0, 3));
    pause = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < n_pix; i++) begin
      hn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023))
                                       : int'($urandom_range(0, 639));
      drive($urandom_range(0, 7) != 0, 1, $urandom_range(0, 3) != 0, hn);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk_25);
    #5;
    rst = 1'b1;
    q.delete();
    hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b0; horizontal_num = '0;
    m_offset = 0; m_started = 0; m_frozen = 0; m_vs_prev = 1;
    #1;
    check("async_reset", {red, green, blue, hsync_out, vsync_out}, {12'h000, 2'b11});
    repeat (3) @(posedge clk_25);
    #5;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_25);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          checks++;
          $display("FAIL px%0d: output slot missed, due cycle %0d seen at %0d", e.id, e.due, cyc);
        end else begin
          check($sformatf("px%0d", e.id), {red, green, blue, hsync_out, vsync_out}, e.val);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b0;
    horizontal_num = '0; pause = 1'b0; speed = 2'd0;
    repeat (2) @(posedge clk_25);
    #1;
    check("reset_state", {red, green, blue, hsync_out, vsync_out}, {12'h000, 2'b11});
    #4;
    rst = 1'b0;

    // Visible pixels before the first frame boundary stay black.
    for (int i = 0; i < 4; i++) drive(1, 1, 1, i * 100);

    // First frame, offset 0: bar edges, last column, out-of-range column, blanking, hsync pulse.
    pause = 1'b0; speed = 2'd3;
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 79);
    drive(1, 1, 1, 80);
    drive(1, 1, 1, 639);
    drive(1, 1, 1, 800);
    drive(0, 1, 0, 100);
    drive(1, 1, 1, 560);

    for (int f = 0; f < 12; f++) frame(14);

    // Mid-line reset while white pixels and a low hsync are in flight.
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    mid_reset();
    for (int i = 0; i < 6; i++) drive(1, 1, 1, i * 80);

    for (int f = 0; f < 8; f++) frame(14);

    repeat (3) drive(1, 1, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_25);
    #3;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d expected outputs never compared, required 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/scroll_bars.md
SCROLL_BARS -- requirements
Module: scroll_bars

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line; horizontal_num range 0..H_ACTIVE-1.
REQ-002 Parameter BAR_WIDTH, default 80, pixels per colour bar; H_ACTIVE SHALL be a multiple of BAR_WIDTH; bar count fixed at 8.
REQ-003 clk_25  input  1  pixel clock, 25 MHz, sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 hsync_in  input  1  horizontal sync from timing generator, active-low.
REQ-006 vsync_in  input  1  vertical sync from timing generator, active-low.
REQ-007 video_on  input  1  visible-area flag, aligned with horizontal_num.
REQ-008 horizontal_num  input  10  current pixel column.
REQ-009 pause  input  1  request to freeze scrolling; sampled only at frame boundary.
REQ-010 speed  input  2  scroll step per frame = speed+1 pixels.
REQ-011 red, green, blue  output  4 each  pixel colour, registered.
REQ-012 hsync_out, vsync_out  output  1 each  syncs delayed to align with colour.

Function
REQ-013 Total latency SHALL be exactly 2 clk_25 cycles from inputs to red/green/blue, hsync_out, vsync_out; syncs and video_on pass through a matching 2-stage delay.
REQ-014 Frame boundary = falling edge of vsync_in (registered previous value 1, current 0), one-cycle internal pulse.
REQ-015 Stage 1 SHALL register pos = horizontal_num + offset, reduced mod H_ACTIVE by single conditional subtract (sum in 11 bits; horizontal_num > H_ACTIVE-1 treated as 0).
REQ-016 Stage 2 SHALL register colour = palette[pos / BAR_WIDTH] when delayed video_on=1, else 0x000 on all channels.
REQ-017 Palette index 0..7: white, yellow, cyan, green, magenta, red, blue, black (each channel 4'hF or 4'h0).
REQ-018 State machine states: WAIT_FRAME, RUN, HOLD.
REQ-019 WAIT_FRAME: colour forced 0 regardless of video_on; on frame boundary -> RUN (pause=0) or HOLD (pause=1).
REQ-020 RUN: on frame boundary, offset <= offset+speed+1, wrapping (if sum >= H_ACTIVE subtract H_ACTIVE); if pause=1 at that boundary -> HOLD instead and offset unchanged.
REQ-021 HOLD: offset constant; on frame boundary with pause=0 -> RUN, increment begins at next boundary.
REQ-022 offset, state and speed SHALL change only on a frame boundary; speed sampled at boundary, mid-frame changes ignored.
REQ-023 offset range 0..H_ACTIVE-1 at all times; offset 639 + step 4 -> 3.

Reset
REQ-024 While rst=1: state WAIT_FRAME, offset 0, all colour outputs 0, hsync_out=1, vsync_out=1, delay stages filled with hsync=1, vsync=1, video_on=0, edge-detect register 1.
REQ-025 Reset asserted mid-frame SHALL take effect immediately (asynchronous); after release, first colour output only after a new frame boundary.

Configuration
REQ-026 Macro SCROLL_BARS_SCROLL_EN defined: behaviour per REQ-018..REQ-023.
REQ-027 Macro SCROLL_BARS_SCROLL_EN undefined: offset fixed 0, pause and speed ignored, state machine reduced to WAIT_FRAME -> RUN, static bars; latency unchanged.

Structure
REQ-028 Shared package vga_pkg holds H_ACTIVE default, BAR_WIDTH default, 12-bit rgb type, palette constant table and state enum.
REQ-029 One sub-module sync_delay (parameter DEPTH, default 2, reset value all-ones) delays hsync/vsync/video_on; instantiated once on a 3-bit bundle.

Verification
REQ-030 Reset then one frame, offset 0: horizontal_num=0 -> red/green/blue=F/F/F two cycles later; horizontal_num=79 -> white; 80 -> F/F/0.
REQ-031 speed=3, pause=0, 3 frame boundaries -> offset 12; horizontal_num=68 -> pos 80 -> yellow.
REQ-032 offset forced to 638 by frames, speed=3 -> next offset 2; horizontal_num=638 -> pos 0 -> white.
REQ-033 pause=1 before boundary N -> offset identical across frames N..N+3; pause=0 at N+3 -> increment at N+4.
REQ-034 video_on=0 with horizontal_num=100 -> colour 0x000; hsync_in low pulse reappears on hsync_out exactly 2 cycles later.
REQ-035 rst asserted mid-line -> outputs 0/sync 1 same cycle; after release, colour stays 0 until first vsync_in falling edge.
